// File: rtl/seg_adder_pkg.sv
// -----------------------------------------------------------------------------
// seg_adder_pkg
// Shared constants and helpers for the carry-segmented pipelined adder.
//   MAX_WIDTH   : widest operand the adder is qualified for.
//   seg_width() : segment width ceil(width/stages).
//   seg_lo()    : low bit index of segment k.
// -----------------------------------------------------------------------------
package seg_adder_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic int seg_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int seg_lo(input int k, input int seg);
        return k * seg;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// -----------------------------------------------------------------------------
// adder_segment
// Combinational ripple adder for one carry segment.
// Ports:
//   a, b : W-bit segment operands
//   cin  : carry into the segment
//   s    : W-bit segment sum
//   cout : carry out of the segment
// -----------------------------------------------------------------------------
module adder_segment
    import seg_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s     = total[W-1:0];
    assign cout  = total[W];

endmodule

// File: rtl/pipelined_segment_adder.sv
// -----------------------------------------------------------------------------
// pipelined_segment_adder
// Pipelined, carry-segmented WIDTH-bit adder/subtractor. The operands are cut
// into STAGES segments; stage k resolves segment k using the registered carry
// of stage k-1. Upper operand bits ride along skewed, resolved lower sum bits
// ride along delayed, so the whole word lines up at the last stage.
// Latency STAGES cycles, throughput one operation per cycle.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready = pipeline advance)
//   a, b, sub            : operands; sub=1 computes a-b
//   out_valid / out_ready: output handshake
//   sum, cout            : result mod 2^WIDTH, carry out (sub: 1 = no borrow)
//   ovf                  : signed overflow, only with SEG_ADDER_OVF_EN defined
//
// Optional feature macro: SEG_ADDER_OVF_EN (adds the ovf output).
// -----------------------------------------------------------------------------
module pipelined_segment_adder
    import seg_adder_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEG_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    // Parameter legality is enforced at elaboration.
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("pipelined_segment_adder: WIDTH=%0d outside 2..%0d", WIDTH, MAX_WIDTH);
    end
    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipelined_segment_adder: STAGES=%0d outside 1..WIDTH", STAGES);
    end
    if ((STAGES - 1) * SEG >= WIDTH) begin : g_empty_segment
        $error("pipelined_segment_adder: STAGES=%0d leaves an empty segment", STAGES);
    end

    logic adv;

    // Stage inputs (combinational view of what stage k consumes).
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic             c_in [STAGES];
    logic             v_in [STAGES];

    // Stage results before registering.
    logic [WIDTH-1:0] s_nx [STAGES];
    logic             c_nx [STAGES];

    // Pipeline registers, one entry per stage.
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] s_p   [STAGES];
    logic             c_p   [STAGES];
    logic             vld_p [STAGES];

`ifdef SEG_ADDER_OVF_EN
    logic ovf_nx;
    logic ovf_p;
`endif

    // Single global enable: the whole pipe moves only when the output slot
    // is empty or being drained, so bubbles hold in place during a stall.
    assign adv = !vld_p[LAST] || out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = seg_lo(k, SEG);
        localparam int HI = (LO + SEG > WIDTH) ? WIDTH - 1 : LO + SEG - 1;
        localparam int SW = HI - LO + 1;
        localparam logic [WIDTH-1:0] MASK =
            ({WIDTH{1'b1}} >> (WIDTH - 1 - HI)) & ({WIDTH{1'b1}} << LO);

        logic [SW-1:0] seg_s;

        if (k == 0) begin : g_head
            // Subtraction as a + ~b + 1: invert once here, inject the +1 as cin.
            assign a_in[k] = a;
            assign b_in[k] = sub ? ~b : b;
            assign s_in[k] = '0;
            assign c_in[k] = sub;
            assign v_in[k] = in_valid;
        end else begin : g_body
            assign a_in[k] = a_p[k-1];
            assign b_in[k] = b_p[k-1];
            assign s_in[k] = s_p[k-1];
            assign c_in[k] = c_p[k-1];
            assign v_in[k] = vld_p[k-1];
        end

        adder_segment #(
            .W (SW)
        ) u_seg (
            .a    (a_in[k][HI:LO]),
            .b    (b_in[k][HI:LO]),
            .cin  (c_in[k]),
            .s    (seg_s),
            .cout (c_nx[k])
        );

        // Splice this segment into the travelling sum word; lower bits were
        // resolved by earlier stages, upper bits are filled in later.
        assign s_nx[k] = (s_in[k] & ~MASK) | (WIDTH'(seg_s) << LO);
    end

`ifdef SEG_ADDER_OVF_EN
    // Carry into the MSB is recovered as a^b^s at the MSB position.
    assign ovf_nx = a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1]
                  ^ s_nx[LAST][WIDTH-1] ^ c_nx[LAST];
`endif

    // ---- stage boundary: all segment registers advance together ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
            end
            s_p[LAST] <= '0;
            c_p[LAST] <= 1'b0;
`ifdef SEG_ADDER_OVF_EN
            ovf_p     <= 1'b0;
`endif
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= v_in[k];
                a_p[k]   <= a_in[k];
                b_p[k]   <= b_in[k];
                s_p[k]   <= s_nx[k];
                c_p[k]   <= c_nx[k];
            end
`ifdef SEG_ADDER_OVF_EN
            ovf_p <= ovf_nx;
`endif
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_p[LAST];
    assign sum       = s_p[LAST];
    assign cout      = c_p[LAST];
`ifdef SEG_ADDER_OVF_EN
    assign ovf       = ovf_p;
`endif

endmodule
